// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: word width, requester ids and the memory arbiter state type.
package lc3_pkg;

    localparam int LC3_WORD_W = 16;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arbState_t;

endpackage

// File: rtl/lc3_arb_pick.sv
// Grant selection between fetch and data requests; data normally wins, but a
// fetch that has waited through MAX_D_BURST data grants is forced through.
module lc3_arb_pick
    import lc3_pkg::*;
#(
    parameter int MAX_D_BURST = 3,
    parameter int BW          = 2
) (
    input  logic          i_req,
    input  logic          d_req,
    input  logic [BW-1:0] burstCnt,
    output logic          grant,
    output logic          grantId
);

    always_comb begin
        grant   = 1'b0;
        grantId = REQ_I;
        if (d_req && !(burstCnt == BW'(MAX_D_BURST) && i_req)) begin
            grant   = 1'b1;
            grantId = REQ_D;
        end else if (i_req) begin
            grant   = 1'b1;
            grantId = REQ_I;
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Arbitrates the single-ported LC-3 memory between instruction fetch and the MEM
// stage, sequencing one fixed-latency access at a time.
module lc3_mem_arbiter
    import lc3_pkg::*;
#(
    parameter int MEM_LAT     = 1,
    parameter int MAX_D_BURST = 3,
    parameter int AW          = LC3_WORD_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic          i_ack,
    output logic [AW-1:0] i_rdata,
    output logic          if_pause,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] d_wdata,
    output logic          d_ack,
    output logic [AW-1:0] d_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [AW-1:0] ram_wdata,
    input  logic [AW-1:0] ram_rdata
);

    // Handshake: a requester raises req with stable address/data and holds it
    // until the one-cycle ack; an ack for a dropped request still pulses.
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int BW = (MAX_D_BURST < 1) ? 1 : $clog2(MAX_D_BURST + 1);

    arbState_t     state, stateNext;
    logic [LW-1:0] latCnt;
    logic [BW-1:0] burstCnt;
    logic          flushed;
    logic          accWrite;
    logic          grant, grantId;
    logic          issue, done;

    lc3_arb_pick #(
        .MAX_D_BURST(MAX_D_BURST),
        .BW         (BW)
    ) u_pick (
        .i_req   (i_req),
        .d_req   (d_req),
        .burstCnt(burstCnt),
        .grant   (grant),
        .grantId (grantId)
    );

    assign if_pause = i_req & ~i_ack;

    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    issue     = 1'b1;
                    stateNext = (grantId == REQ_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (latCnt == '0) begin
                    done      = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            latCnt    <= '0;
            burstCnt  <= '0;
            flushed   <= 1'b0;
            accWrite  <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state  <= stateNext;
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            i_ack  <= 1'b0;
            d_ack  <= 1'b0;
            if (issue) begin
                ram_en <= 1'b1;
                latCnt <= LW'(MEM_LAT);
                if (grantId == REQ_D) begin
                    ram_addr  <= d_addr;
                    ram_we    <= d_we;
                    ram_wdata <= d_wdata;
                    accWrite  <= d_we;
                    if (!i_req)
                        burstCnt <= '0;
                    else if (burstCnt != BW'(MAX_D_BURST))
                        burstCnt <= burstCnt + 1'b1;
                end else begin
                    ram_addr <= i_addr;
                    accWrite <= 1'b0;
                    flushed  <= i_flush;
                    burstCnt <= '0;
                end
            end else if (state == IDLE) begin
                if (!i_req)
                    burstCnt <= '0;
            end else begin
                if (latCnt != '0)
                    latCnt <= latCnt - 1'b1;
                if (state == BUSY_I && i_flush)
                    flushed <= 1'b1;
                // A redirect arriving in the completion cycle still kills the ack.
                if (done) begin
                    flushed <= 1'b0;
                    if (state == BUSY_I) begin
                        if (!(flushed || i_flush)) begin
                            i_ack   <= 1'b1;
                            i_rdata <= ram_rdata;
                        end
                    end else begin
                        d_ack <= 1'b1;
                        if (!accWrite)
                            d_rdata <= ram_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: a cycle-numbered access model checks a
// MEM_LAT=1 instance every cycle; a MEM_LAT=3 instance is pinned by literals.
module tb_lc3_mem_arbiter;
  import lc3_pkg::*;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int MAXB  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        iReqA = 0, iFlushA = 0, dReqA = 0, dWeA = 0;
  logic [15:0] iAddrA = 0, dAddrA = 0, dWdataA = 0, ramRdataA = 16'hDEAD;
  logic        iAckA, dAckA, ifPauseA, ramEnA, ramWeA;
  logic [15:0] iRdataA, dRdataA, ramAddrA, ramWdataA;

  logic        iReqB = 0, iFlushB = 0, dReqB = 0, dWeB = 0;
  logic [15:0] iAddrB = 0, dAddrB = 0, dWdataB = 0, ramRdataB = 16'hDEAD;
  logic        iAckB, dAckB, ifPauseB, ramEnB, ramWeB;
  logic [15:0] iRdataB, dRdataB, ramAddrB, ramWdataB;

  logic [15:0] memA [0:65535];
  logic [15:0] memB [0:65535];
  logic [15:0] dlyA [0:LAT_A-1];
  logic [15:0] dlyB [0:LAT_B-1];

  int checks = 0;
  int errors = 0;

  lc3_mem_arbiter #(.MEM_LAT(LAT_A), .MAX_D_BURST(MAXB), .AW(16)) dutA (
    .clk(clk), .reset(reset),
    .i_req(iReqA), .i_addr(iAddrA), .i_flush(iFlushA), .i_ack(iAckA), .i_rdata(iRdataA),
    .if_pause(ifPauseA),
    .d_req(dReqA), .d_we(dWeA), .d_addr(dAddrA), .d_wdata(dWdataA), .d_ack(dAckA),
    .d_rdata(dRdataA),
    .ram_en(ramEnA), .ram_we(ramWeA), .ram_addr(ramAddrA), .ram_wdata(ramWdataA),
    .ram_rdata(ramRdataA)
  );

  lc3_mem_arbiter #(.MEM_LAT(LAT_B), .MAX_D_BURST(MAXB), .AW(16)) dutB (
    .clk(clk), .reset(reset),
    .i_req(iReqB), .i_addr(iAddrB), .i_flush(iFlushB), .i_ack(iAckB), .i_rdata(iRdataB),
    .if_pause(ifPauseB),
    .d_req(dReqB), .d_we(dWeB), .d_addr(dAddrB), .d_wdata(dWdataB), .d_ack(dAckB),
    .d_rdata(dRdataB),
    .ram_en(ramEnB), .ram_we(ramWeB), .ram_addr(ramAddrB), .ram_wdata(ramWdataB),
    .ram_rdata(ramRdataB)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkB(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fixed-latency memories: read data valid only LAT cycles after the strobe cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = LAT_A - 1; i > 0; i--) dlyA[i] = dlyA[i-1];
      dlyA[0] = (ramEnA === 1'b1 && ramWeA === 1'b0) ? memA[ramAddrA] : 16'hDEAD;
      if (ramEnA === 1'b1 && ramWeA === 1'b1) memA[ramAddrA] = ramWdataA;
      @(posedge clk);
      #1;
      ramRdataA = dlyA[LAT_A-1];
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = LAT_B - 1; i > 0; i--) dlyB[i] = dlyB[i-1];
      dlyB[0] = (ramEnB === 1'b1 && ramWeB === 1'b0) ? memB[ramAddrB] : 16'hDEAD;
      if (ramEnB === 1'b1 && ramWeB === 1'b1) memB[ramAddrB] = ramWdataB;
      @(posedge clk);
      #1;
      ramRdataB = dlyB[LAT_B-1];
    end
  end

  // Access model for dutA: a granted access occupies cycles g+1..g+LAT+1, acks in g+LAT+2.
  int          cyc = 0;
  int          mGrant = 0;
  int          mBurst = 0;
  bit          mValid = 0, mBusy = 0, mIsData = 0, mWe = 0, mFl = 0, mIAck = 0, mDAck = 0;
  logic [15:0] mAddr = 0, mWd = 0, mIRd = 0, mDRd = 0;

  always @(posedge clk) begin
    int endCyc;
    endCyc = cyc;
    cyc = cyc + 1;
    mIAck = 0;
    mDAck = 0;
    if (reset) begin
      mValid = 1; mBusy = 0; mBurst = 0; mFl = 0;
      mIRd = 0; mDRd = 0; mAddr = 0; mWd = 0; mWe = 0;
    end else if (mBusy) begin
      if (!mIsData && iFlushA) mFl = 1;
      if (endCyc == mGrant + LAT_A + 1) begin
        mBusy = 0;
        if (mIsData) begin
          mDAck = 1;
          if (!mWe) mDRd = ramRdataA;
        end else if (!mFl) begin
          mIAck = 1;
          mIRd = ramRdataA;
        end
        mFl = 0;
      end
    end else begin
      if (dReqA && !(mBurst == MAXB && iReqA)) begin
        mBusy = 1; mIsData = 1; mGrant = endCyc;
        mAddr = dAddrA; mWe = dWeA; mWd = dWdataA;
        mBurst = iReqA ? ((mBurst < MAXB) ? mBurst + 1 : MAXB) : 0;
      end else if (iReqA) begin
        mBusy = 1; mIsData = 0; mGrant = endCyc;
        mAddr = iAddrA; mWe = 0; mFl = iFlushA; mBurst = 0;
      end else begin
        mBurst = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      logic expEn;
      expEn = mBusy && (cyc == mGrant + 1);
      chkB("cmp_ram_en", ramEnA, expEn);
      chkB("cmp_ram_we", ramWeA, expEn && mWe);
      if (expEn) chk("cmp_ram_addr", ramAddrA, mAddr);
      if (expEn && mWe) chk("cmp_ram_wdata", ramWdataA, mWd);
      chkB("cmp_i_ack", iAckA, mIAck);
      chkB("cmp_d_ack", dAckA, mDAck);
      chk("cmp_i_rdata", iRdataA, mIRd);
      chk("cmp_d_rdata", dRdataA, mDRd);
      chkB("cmp_if_pause", ifPauseA, iReqA & ~mIAck);
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      memA[i] = 16'(i) ^ 16'h5A5A;
      memB[i] = 16'(i) ^ 16'hA5A5;
    end
    memA[16'h3000] = 16'h1234;
    memA[16'h4000] = 16'h5678;
    memA[16'h3005] = 16'h7777;
    memB[16'hFFFF] = 16'hCAFE;

    reset = 1;
    tick();
    tick();
    chkB("rst_ram_en", ramEnA, 1'b0);
    chkB("rst_ram_we", ramWeA, 1'b0);
    chk("rst_ram_addr", ramAddrA, 16'h0000);
    chk("rst_ram_wdata", ramWdataA, 16'h0000);
    chkB("rst_i_ack", iAckA, 1'b0);
    chkB("rst_d_ack", dAckA, 1'b0);
    chk("rst_i_rdata", iRdataA, 16'h0000);
    chk("rst_d_rdata", dRdataA, 16'h0000);

    // Single fetch.
    reset = 0; iReqA = 1; iAddrA = 16'h3000;
    tick();
    chkB("s1_ram_en", ramEnA, 1'b1);
    chk("s1_ram_addr", ramAddrA, 16'h3000);
    chkB("s1_pause_c1", ifPauseA, 1'b1);
    tick();
    chkB("s1_en_one_cycle", ramEnA, 1'b0);
    chkB("s1_no_early_ack", iAckA, 1'b0);
    chkB("s1_pause_c2", ifPauseA, 1'b1);
    tick();
    chkB("s1_i_ack", iAckA, 1'b1);
    chk("s1_i_rdata", iRdataA, 16'h1234);
    chkB("s1_pause_low", ifPauseA, 1'b0);
    iReqA = 0;
    tick();

    // Fetch and data together: data first, fetch issued in the d_ack cycle.
    iReqA = 1; iAddrA = 16'h3000; dReqA = 1; dWeA = 0; dAddrA = 16'h4000;
    tick();
    chkB("s2_d_en", ramEnA, 1'b1);
    chk("s2_d_addr", ramAddrA, 16'h4000);
    tick();
    tick();
    chkB("s2_d_ack", dAckA, 1'b1);
    chk("s2_d_rdata", dRdataA, 16'h5678);
    chkB("s2_pause_held", ifPauseA, 1'b1);
    dReqA = 0;
    tick();
    chkB("s2_i_en", ramEnA, 1'b1);
    chk("s2_i_addr", ramAddrA, 16'h3000);
    tick();
    tick();
    chkB("s2_i_ack", iAckA, 1'b1);
    chk("s2_i_rdata", iRdataA, 16'h1234);
    iReqA = 0;
    tick();

    // Data burst of writes against a held fetch.
    dReqA = 1; dWeA = 1; dAddrA = 16'h5000; dWdataA = 16'hBEEF; iReqA = 1; iAddrA = 16'h3002;
    for (int k = 0; k < 5; k++) begin
      tick();
      chkB("s3_en", ramEnA, 1'b1);
      chkB("s3_we", ramWeA, k != 3);
      chk("s3_addr", ramAddrA, (k == 3) ? 16'h3002 : 16'h5000);
      if (k != 3) chk("s3_wdata", ramWdataA, 16'hBEEF);
      tick();
      tick();
      if (k == 3) begin
        chkB("s3_i_ack", iAckA, 1'b1);
        chk("s3_i_rdata", iRdataA, 16'h6A58);
      end
    end
    dReqA = 0; dWeA = 0; iReqA = 0;
    tick();

    // Redirect while a fetch is in flight.
    iReqA = 1; iAddrA = 16'h3004;
    tick();
    chkB("s4_en", ramEnA, 1'b1);
    chk("s4_addr", ramAddrA, 16'h3004);
    iFlushA = 1; iAddrA = 16'h3005;
    tick();
    iFlushA = 0;
    tick();
    chkB("s4_no_ack", iAckA, 1'b0);
    chk("s4_rdata_kept", iRdataA, 16'h6A58);
    tick();
    chkB("s4_new_en", ramEnA, 1'b1);
    chk("s4_new_addr", ramAddrA, 16'h3005);
    tick();
    tick();
    chkB("s4_new_ack", iAckA, 1'b1);
    chk("s4_new_rdata", iRdataA, 16'h7777);
    iReqA = 0;
    tick();

    // Reset during a data read.
    dReqA = 1; dWeA = 0; dAddrA = 16'h4001;
    tick();
    chkB("s5_en", ramEnA, 1'b1);
    tick();
    reset = 1; dReqA = 0;
    tick();
    reset = 0;
    chkB("s5_no_d_ack", dAckA, 1'b0);
    chkB("s5_ram_en", ramEnA, 1'b0);
    chk("s5_ram_addr", ramAddrA, 16'h0000);
    chk("s5_i_rdata", iRdataA, 16'h0000);
    chk("s5_d_rdata", dRdataA, 16'h0000);
    tick();
    chkB("s5_still_no_ack", dAckA, 1'b0);
    iReqA = 1; iAddrA = 16'h3000;
    tick();
    chkB("s5_f_en", ramEnA, 1'b1);
    chk("s5_f_addr", ramAddrA, 16'h3000);
    tick();
    tick();
    chkB("s5_f_ack", iAckA, 1'b1);
    chk("s5_f_rdata", iRdataA, 16'h1234);
    iReqA = 0;
    tick();

    // Longer latency at the top of the address space.
    iReqB = 1; iAddrB = 16'hFFFF;
    tick();
    chkB("s6_i_en", ramEnB, 1'b1);
    chk("s6_i_addr", ramAddrB, 16'hFFFF);
    for (int c = 2; c < 5; c++) begin
      tick();
      chkB("s6_i_wait", iAckB, 1'b0);
      chkB("s6_pause", ifPauseB, 1'b1);
    end
    tick();
    chkB("s6_i_ack", iAckB, 1'b1);
    chk("s6_i_rdata", iRdataB, 16'hCAFE);
    iReqB = 0; dReqB = 1; dWeB = 0; dAddrB = 16'hFFFF;
    tick();
    chkB("s6_d_en", ramEnB, 1'b1);
    chkB("s6_d_we", ramWeB, 1'b0);
    chk("s6_d_addr", ramAddrB, 16'hFFFF);
    for (int c = 2; c < 5; c++) begin
      tick();
      chkB("s6_d_wait", dAckB, 1'b0);
    end
    tick();
    chkB("s6_d_ack", dAckB, 1'b1);
    chk("s6_d_rdata", dRdataB, 16'hCAFE);
    dReqB = 0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
